// File: rtl/sopc_2_key_pio_in_if.sv
// Avalon-MM slave bus bundle for the pushbutton/switch input PIO.
// The master modport drives the strobes and data; the slave returns readdata and the level irq.
interface sopc_2_key_pio_in_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, read_n, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, read_n, write_n, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/sopc_2_key_pio_in.sv
// Avalon-MM input PIO: synchronises in_port, detects edges into sticky W1C flags, raises a maskable irq.
// Optional per-bit debounce filter is enabled by defining SOPC_2_KEY_PIO_DEBOUNCE_EN.
module sopc_2_key_pio_in #(
   parameter int WIDTH           = 4,
   parameter int EDGE_TYPE       = 1,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   sopc_2_key_pio_in_if.slave bus
);

   logic [WIDTH-1:0] sync1, sync2, filt, prev;
   logic [WIDTH-1:0] edgecapture, irqmask;
   logic [WIDTH-1:0] rise, fall, raw_evt, evt;
   logic [WIDTH-1:0] ec_clear, ec_next;
   logic [15:0]      event_cnt;
   logic [1:0]       settle;
   logic [31:0]      rd_mux;
   logic             wr, rd;
   logic             unused_wdata;

   assign wr = bus.chipselect & ~bus.write_n;
   assign rd = bus.chipselect & ~bus.read_n;
   assign unused_wdata = ^bus.writedata;

`ifdef SOPC_2_KEY_PIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   logic [CNT_W-1:0] db_cnt [WIDTH];

   // A bit only follows sync2 after it has disagreed for DEBOUNCE_CYCLES straight cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt <= '0;
         for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               filt[i]   <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   assign filt = sync2;
`endif

   // Edges are ignored until the settle counter saturates, hiding the chain filling after reset.
   always_comb begin
      rise = filt & ~prev;
      fall = ~filt & prev;
      case (EDGE_TYPE)
         0:       raw_evt = rise;
         1:       raw_evt = fall;
         default: raw_evt = rise | fall;
      endcase
      evt      = (settle == 2'd3) ? raw_evt : '0;
      ec_clear = (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;
      ec_next  = (edgecapture & ~ec_clear) | evt;
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         2'd0:    rd_mux = 32'(filt);
         2'd1:    rd_mux = 32'(irqmask);
         2'd2:    rd_mux = 32'(edgecapture);
         default: rd_mux = 32'(event_cnt);
      endcase
   end

   // irq follows the registered capture/mask, so it lags a new capture bit by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1        <= '0;
         sync2        <= '0;
         prev         <= '0;
         settle       <= '0;
         edgecapture  <= '0;
         irqmask      <= '0;
         event_cnt    <= '0;
         bus.readdata <= '0;
         bus.irq      <= 1'b0;
      end else begin
         sync1       <= in_port;
         sync2       <= sync1;
         prev        <= filt;
         edgecapture <= ec_next;
         if (settle != 2'd3) settle <= settle + 2'd1;
         if (wr && bus.address == 2'd1) irqmask <= bus.writedata[WIDTH-1:0];
         if (wr && bus.address == 2'd3) begin
            event_cnt <= '0;
         end else if (|evt) begin
            event_cnt <= event_cnt + 16'd1;
         end
         bus.irq <= |(edgecapture & irqmask);
         if (rd) bus.readdata <= rd_mux;
      end
   end

endmodule
